// File: rtl/noc_burst_sched_if.sv
// Command/completion channel between the burst scheduler and the NoC master unit.
// Latency: none (wires only).
// Backpressure: cmd_ready from the NoC side stalls the command held on cmd_valid.
interface noc_burst_sched_if #(
  parameter int AW   = 32,
  parameter int LENW = 8
);
  logic            cmd_valid;
  logic            cmd_ready;
  logic [AW-1:0]   cmd_addr;
  logic [LENW-1:0] cmd_len;
  logic [2:0]      cmd_id;
  logic            done_valid;

  // Scheduler side: drives the command, sees ready and completions.
  modport master (
    output cmd_valid, cmd_addr, cmd_len, cmd_id,
    input  cmd_ready, done_valid
  );

  // NoC side: consumes the command, reports ready and completions.
  modport slave (
    input  cmd_valid, cmd_addr, cmd_len, cmd_id,
    output cmd_ready, done_valid
  );
endinterface

// File: rtl/noc_burst_sched.sv
// Round-robin burst scheduler sharing one NoC command port among NREQ requesters.
// Latency: req seen in IDLE -> gnt next cycle (ARB) -> cmd_valid the cycle after; 3 cycles per command at best.
// Backpressure: command held stable until cmd_ready; new grants blocked while outst == MAX_OUTST or start low.
// Optional watchdog on outstanding completions enabled by defining NOC_SCHED_WDOG_EN.
module noc_burst_sched #(
  parameter int NREQ      = 4,
  parameter int AW        = 32,
  parameter int LENW      = 8,
  parameter int MAX_OUTST = 4,
  parameter int TIMEOUT   = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*LENW-1:0] req_len,
  output logic [NREQ-1:0]      gnt,
  noc_burst_sched_if.master    cmd,
  output logic [3:0]           outst,
  output logic                 busy,
  output logic                 err
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARB   = 2'd1;
  localparam logic [1:0] ST_ISSUE = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [2:0]      rr_ptr_q, rr_ptr_d;
  logic [AW-1:0]   cmd_addr_q, cmd_addr_d;
  logic [LENW-1:0] cmd_len_q, cmd_len_d;
  logic [2:0]      cmd_id_q, cmd_id_d;
  logic [3:0]      outst_q, outst_d;
  logic            err_q, err_d;

  logic            win_vld;
  logic [2:0]      win_idx;
  logic [3:0]      cand;
  logic [AW-1:0]   win_addr;
  logic [LENW-1:0] win_len;
  logic            hs;
  logic            wdog_hit;

  assign hs = (state_q == ST_ISSUE) && cmd.cmd_ready;

  // Round-robin search: first requesting index at or after rr_ptr, wrapping.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = {1'b0, rr_ptr_q} + 4'(i);
      if (cand >= 4'(NREQ)) cand = cand - 4'(NREQ);
      if (!win_vld && req[cand[IW-1:0]]) begin
        win_vld = 1'b1;
        win_idx = cand[2:0];
      end
    end
  end

  // Select the winner's address and length from the packed request buses.
  always_comb begin
    win_addr = '0;
    win_len  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (3'(i) == win_idx) begin
        win_addr = req_addr[i*AW +: AW];
        win_len  = req_len[i*LENW +: LENW];
      end
    end
  end

  // One-cycle grant pulse to the winner while in ARB.
  always_comb begin
    gnt = '0;
    if (state_q == ST_ARB && win_vld) gnt = {{(NREQ-1){1'b0}}, 1'b1} << win_idx;
  end

  // Scheduler FSM: wait for eligible request, arbitrate, hold command until accepted.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    cmd_addr_d = cmd_addr_q;
    cmd_len_d  = cmd_len_q;
    cmd_id_d   = cmd_id_q;
    case (state_q)
      ST_IDLE: begin
        if (start && (req != '0) && (outst_q < 4'(MAX_OUTST))) state_d = ST_ARB;
      end
      ST_ARB: begin
        if (win_vld) begin
          cmd_addr_d = win_addr;
          cmd_len_d  = win_len;
          cmd_id_d   = win_idx;
          state_d    = ST_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (cmd.cmd_ready) begin
          rr_ptr_d = (cmd_id_q == 3'(NREQ-1)) ? 3'd0 : cmd_id_q + 3'd1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef NOC_SCHED_WDOG_EN
  localparam int WW = $clog2(TIMEOUT + 1);
  logic [WW-1:0] wdog_q, wdog_d;

  // Watchdog: counts cycles with commands outstanding and no completion, saturating at TIMEOUT.
  always_comb begin
    wdog_d = wdog_q;
    if (cmd.done_valid || (outst_q == 4'd0)) wdog_d = '0;
    else if (wdog_q != WW'(TIMEOUT)) wdog_d = wdog_q + 1'b1;
    wdog_hit = (wdog_d == WW'(TIMEOUT));
  end

  // Watchdog counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) wdog_q <= '0;
    else     wdog_q <= wdog_d;
  end
`else
  assign wdog_hit = 1'b0;
`endif

  // Outstanding count and sticky error; simultaneous issue and completion cancel out.
  always_comb begin
    outst_d = outst_q;
    err_d   = err_q;
    if (hs && !cmd.done_valid) begin
      outst_d = outst_q + 4'd1;
    end else if (!hs && cmd.done_valid) begin
      if (outst_q != 4'd0) outst_d = outst_q - 4'd1;
      else                 err_d   = 1'b1;
    end
    if (wdog_hit) err_d = 1'b1;
  end

  // State registers; reset drops cmd_valid immediately and loses the outstanding count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= '0;
      cmd_addr_q <= '0;
      cmd_len_q  <= '0;
      cmd_id_q   <= '0;
      outst_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      cmd_addr_q <= cmd_addr_d;
      cmd_len_q  <= cmd_len_d;
      cmd_id_q   <= cmd_id_d;
      outst_q    <= outst_d;
      err_q      <= err_d;
    end
  end

  assign cmd.cmd_valid = (state_q == ST_ISSUE);
  assign cmd.cmd_addr  = cmd_addr_q;
  assign cmd.cmd_len   = cmd_len_q;
  assign cmd.cmd_id    = cmd_id_q;
  assign outst         = outst_q;
  assign err           = err_q;
  assign busy          = (state_q != ST_IDLE) || (outst_q != 4'd0);

endmodule

// File: tb/tb_noc_burst_sched.sv
// Self-checking bench for noc_burst_sched: vector table, directed corner cases, random vs. transaction model.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
// Watchdog timing is checked when NOC_SCHED_WDOG_EN is defined, absence of spurious err otherwise.
module tb_noc_burst_sched;
  localparam int NREQ = 4;
  localparam int AW   = 32;
  localparam int LENW = 8;
  localparam int MAXO = 4;
  localparam int TMO  = 16;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  logic [NREQ-1:0]      req;
  logic [NREQ*AW-1:0]   req_addr;
  logic [NREQ*LENW-1:0] req_len;
  logic [NREQ-1:0]      gnt;
  logic [3:0]           outst;
  logic                 busy;
  logic                 err;

  noc_burst_sched_if #(.AW(AW), .LENW(LENW)) cif ();

  noc_burst_sched #(
    .NREQ(NREQ), .AW(AW), .LENW(LENW), .MAX_OUTST(MAXO), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .req(req),
    .req_addr(req_addr), .req_len(req_len), .gnt(gnt),
    .cmd(cif), .outst(outst), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [AW-1:0]   a_addr [NREQ];
  logic [LENW-1:0] a_len  [NREQ];

  typedef struct {
    logic       st;
    logic [3:0] rq;
    logic       rdy;
    logic       dn;
    logic [3:0] e_gnt;
    logic       e_cv;
    logic [2:0] e_id;
    logic [3:0] e_outst;
    logic       e_err;
    logic       e_busy;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic pack();
    for (int i = 0; i < NREQ; i++) begin
      req_addr[i*AW +: AW]     = a_addr[i];
      req_len[i*LENW +: LENW]  = a_len[i];
    end
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    start          = 1'b0;
    req            = '0;
    cif.cmd_ready  = 1'b0;
    cif.done_valid = 1'b0;
    pack();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic vec_t mk(logic st, logic [3:0] rq, logic rdy, logic dn, logic [3:0] eg,
                              logic ecv, logic [2:0] eid, logic [3:0] eo, logic ee, logic eb);
    vec_t v;
    v.st = st; v.rq = rq; v.rdy = rdy; v.dn = dn; v.e_gnt = eg;
    v.e_cv = ecv; v.e_id = eid; v.e_outst = eo; v.e_err = ee; v.e_busy = eb;
    return v;
  endfunction

  // random-phase state
  logic [3:0] rq_v;
  int         m_ptr, m_outst, n_hs, w;
  logic       m_err, prev_elig, have_pend, hs, dn;
  logic [2:0] p_id;
  logic [AW-1:0]   p_addr;
  logic [LENW-1:0] p_len;

  initial begin
    int ids[$];
    int tms[$];
    int cnt, late_gnt, k;
    logic found, pend_done;

    a_addr[0] = 32'h0000_A000; a_len[0] = 8'd3;
    a_addr[1] = 32'h0000_B000; a_len[1] = 8'd7;
    a_addr[2] = 32'h0000_1000; a_len[2] = 8'd15;
    a_addr[3] = 32'h0000_D000; a_len[3] = 8'd1;

    // ---------------- vector table ----------------
    // single request from requester 2
    tbl.push_back(mk(1, 4'b0100, 1, 0, 4'b0000, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 4'b0100, 1, 0, 4'b0100, 0, 0, 0, 0, 1));
    tbl.push_back(mk(1, 4'b0000, 1, 0, 4'b0000, 1, 2, 0, 0, 1));
    tbl.push_back(mk(1, 4'b0000, 1, 0, 4'b0000, 0, 0, 1, 0, 1));
    tbl.push_back(mk(1, 4'b0000, 1, 1, 4'b0000, 0, 0, 1, 0, 1));
    tbl.push_back(mk(1, 4'b0000, 1, 0, 4'b0000, 0, 0, 0, 0, 0));
    // backpressure: pointer is at 3, requester 3 wins, stalls 10 cycles
    tbl.push_back(mk(1, 4'b1111, 0, 0, 4'b0000, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 4'b1111, 0, 0, 4'b1000, 0, 0, 0, 0, 1));
    for (int i = 0; i < 10; i++)
      tbl.push_back(mk(1, 4'b0111, 0, 0, 4'b0000, 1, 3, 0, 0, 1));
    tbl.push_back(mk(1, 4'b0111, 1, 0, 4'b0000, 1, 3, 0, 0, 1));
    // start low: no new arbitration
    tbl.push_back(mk(0, 4'b0111, 1, 0, 4'b0000, 0, 0, 1, 0, 1));
    tbl.push_back(mk(0, 4'b0111, 1, 0, 4'b0000, 0, 0, 1, 0, 1));
    tbl.push_back(mk(0, 4'b0111, 1, 1, 4'b0000, 0, 0, 1, 0, 1));
    tbl.push_back(mk(0, 4'b0111, 0, 0, 4'b0000, 0, 0, 0, 0, 0));
    // start falls during ARB: command still completes, then scheduler stays idle
    tbl.push_back(mk(1, 4'b0111, 0, 0, 4'b0000, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 4'b0111, 0, 0, 4'b0001, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 4'b0110, 1, 0, 4'b0000, 1, 0, 0, 0, 1));
    tbl.push_back(mk(0, 4'b0110, 1, 0, 4'b0000, 0, 0, 1, 0, 1));
    tbl.push_back(mk(0, 4'b0110, 1, 0, 4'b0000, 0, 0, 1, 0, 1));
    tbl.push_back(mk(0, 4'b0110, 1, 1, 4'b0000, 0, 0, 1, 0, 1));
    tbl.push_back(mk(0, 4'b0000, 1, 0, 4'b0000, 0, 0, 0, 0, 0));
    // completion underflow sets sticky err
    tbl.push_back(mk(0, 4'b0000, 1, 1, 4'b0000, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 4'b0000, 1, 0, 4'b0000, 0, 0, 0, 1, 0));
    tbl.push_back(mk(1, 4'b0000, 1, 0, 4'b0000, 0, 0, 0, 1, 0));

    do_reset();
    #1;
    check("rst_addr", cif.cmd_addr, 0);
    check("rst_len", cif.cmd_len, 0);
    check("rst_id", cif.cmd_id, 0);
    check("rst_valid", cif.cmd_valid, 0);

    foreach (tbl[i]) begin
      @(negedge clk);
      start          = tbl[i].st;
      req            = tbl[i].rq;
      cif.cmd_ready  = tbl[i].rdy;
      cif.done_valid = tbl[i].dn;
      #1;
      check($sformatf("tbl%0d_gnt", i), gnt, tbl[i].e_gnt);
      check($sformatf("tbl%0d_valid", i), cif.cmd_valid, tbl[i].e_cv);
      check($sformatf("tbl%0d_outst", i), outst, tbl[i].e_outst);
      check($sformatf("tbl%0d_err", i), err, tbl[i].e_err);
      check($sformatf("tbl%0d_busy", i), busy, tbl[i].e_busy);
      if (tbl[i].e_cv) begin
        check($sformatf("tbl%0d_id", i), cif.cmd_id, tbl[i].e_id);
        check($sformatf("tbl%0d_addr", i), cif.cmd_addr, a_addr[tbl[i].e_id[1:0]]);
        check($sformatf("tbl%0d_len", i), cif.cmd_len, a_len[tbl[i].e_id[1:0]]);
      end
    end

    // ---------------- fairness ----------------
    do_reset();
    pend_done = 1'b0;
    for (int c = 0; c < 60 && ids.size() < 5; c++) begin
      @(negedge clk);
      start = 1'b1; req = 4'b1111; cif.cmd_ready = 1'b1;
      cif.done_valid = pend_done;
      #1;
      pend_done = cif.cmd_valid;
      if (cif.cmd_valid) begin
        ids.push_back(int'(cif.cmd_id));
        tms.push_back(c);
      end
    end
    check("fair_count", ids.size(), 5);
    if (ids.size() == 5) begin
      for (int i = 0; i < 5; i++) check($sformatf("fair_id%0d", i), ids[i], i % 4);
      for (int i = 1; i < 5; i++) check($sformatf("fair_gap%0d", i), tms[i] - tms[i-1], 3);
    end

    // ---------------- outstanding limit ----------------
    do_reset();
    cnt = 0; late_gnt = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      start = 1'b1; req = 4'b1111; cif.cmd_ready = 1'b1; cif.done_valid = 1'b0;
      #1;
      if (cif.cmd_valid) cnt++;
      if (c >= 15 && gnt != '0) late_gnt++;
    end
    check("lim_cmds", cnt, 4);
    check("lim_outst", outst, 4);
    check("lim_no_gnt", late_gnt, 0);
    check("lim_busy", busy, 1);
    @(negedge clk); cif.done_valid = 1'b1;
    @(negedge clk); cif.done_valid = 1'b0;
    #1;
    check("lim_dec", outst, 3);
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      if (c != 0) begin @(negedge clk); #1; end
      found = cif.cmd_valid;
    end
    check("lim_fifth", found, 1);
    @(negedge clk); #1;
    check("lim_refill", outst, 4);
    // free one slot, then let a handshake coincide with a completion
    @(negedge clk); cif.done_valid = 1'b1;
    @(negedge clk); cif.done_valid = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      #1;
      found = cif.cmd_valid;
      if (!found) @(negedge clk);
    end
    check("sim_found", found, 1);
    check("sim_before", outst, 3);
    cif.done_valid = 1'b1;
    @(negedge clk); cif.done_valid = 1'b0;
    #1;
    check("sim_after", outst, 3);
    check("sim_err", err, 0);

    // ---------------- reset mid-ISSUE ----------------
    do_reset();
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      @(negedge clk);
      start = 1'b1; req = 4'b0100; cif.cmd_ready = 1'b1;
      #1;
      found = cif.cmd_valid;
    end
    check("mid_first", found, 1);
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      @(negedge clk);
      req = 4'b1111; cif.cmd_ready = 1'b0;
      #1;
      found = cif.cmd_valid;
    end
    check("mid_issue", found, 1);
    check("mid_id", cif.cmd_id, 3);
    check("mid_outst_pre", outst, 1);
    rst = 1'b1;
    #1;
    check("mid_valid", cif.cmd_valid, 0);
    check("mid_gnt", gnt, 0);
    check("mid_addr", cif.cmd_addr, 0);
    check("mid_len", cif.cmd_len, 0);
    check("mid_cid", cif.cmd_id, 0);
    check("mid_outst", outst, 0);
    check("mid_busy", busy, 0);
    check("mid_err", err, 0);
    @(negedge clk);
    rst = 1'b0; cif.cmd_ready = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 6 && !found; c++) begin
      @(negedge clk); #1;
      if (gnt != '0) begin
        found = 1'b1;
        check("mid_regnt", gnt, 4'b0001);
      end
    end
    check("mid_regnt_seen", found, 1);

    // ---------------- watchdog ----------------
    do_reset();
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      @(negedge clk);
      start = 1'b1; cif.cmd_ready = 1'b1; cif.done_valid = 1'b0;
      req = (c < 2) ? 4'b0001 : 4'b0000;
      #1;
      found = cif.cmd_valid;
    end
    check("wd_issue", found, 1);
    k = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk); req = '0; #1;
`ifdef NOC_SCHED_WDOG_EN
      if (c == TMO - 1) check("wd_before", err, 0);
      if (c == TMO) begin
        check("wd_fire", err, 1);
        check("wd_outst", outst, 1);
      end
`else
      if (c == 40) check("wd_none", err, 0);
`endif
    end

    // ---------------- random vs. transaction model ----------------
    do_reset();
    rq_v = '0; m_ptr = 0; m_outst = 0; m_err = 1'b0; prev_elig = 1'b0;
    have_pend = 1'b0; n_hs = 0; p_id = '0; p_addr = '0; p_len = '0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      start          = ($urandom_range(0, 15) != 0);
      req            = rq_v;
      pack();
      cif.cmd_ready  = ($urandom_range(0, 2) != 0);
      dn             = (m_outst > 0) && ($urandom_range(0, 2) == 0);
      cif.done_valid = dn;
      #1;
      check("rnd_outst", outst, m_outst);
      check("rnd_err", err, m_err);
      check("rnd_gnt_when", (gnt != '0), prev_elig);
      if (gnt != '0) begin
        w = -1;
        for (int j = 0; j < NREQ; j++)
          if (w < 0 && rq_v[(m_ptr + j) % NREQ]) w = (m_ptr + j) % NREQ;
        check("rnd_gnt", gnt, (w >= 0) ? (4'b0001 << w) : 4'b0000);
        p_id = 3'(w); p_addr = a_addr[w]; p_len = a_len[w];
        have_pend = 1'b1;
      end
      hs = 1'b0;
      if (cif.cmd_valid) begin
        check("rnd_pend", have_pend, 1);
        check("rnd_id", cif.cmd_id, p_id);
        check("rnd_addr", cif.cmd_addr, p_addr);
        check("rnd_len", cif.cmd_len, p_len);
        if (cif.cmd_ready) begin
          hs = 1'b1; n_hs++;
          m_ptr = (int'(p_id) + 1) % NREQ;
          have_pend = 1'b0;
        end
      end
      check("rnd_busy", busy, (gnt != '0) || cif.cmd_valid || (m_outst != 0));
      prev_elig = !cif.cmd_valid && (gnt == '0) && (rq_v != '0) && start && (m_outst < MAXO);
      if (hs && !dn) m_outst++;
      else if (dn && !hs) begin
        if (m_outst > 0) m_outst--;
        else m_err = 1'b1;
      end
      for (int j = 0; j < NREQ; j++) begin
        if (gnt[j]) begin
          rq_v[j] = ($urandom_range(0, 1) == 1);
          if (rq_v[j]) begin a_addr[j] = $urandom; a_len[j] = LENW'($urandom); end
        end else if (!rq_v[j] && $urandom_range(0, 3) == 0) begin
          rq_v[j] = 1'b1;
          a_addr[j] = $urandom; a_len[j] = LENW'($urandom);
        end
      end
    end
    check("rnd_progress", (n_hs > 200), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish, limit 1000000");
    $fatal(1);
  end

endmodule
